// File: rtl/collision_ctrl.sv
// collision_ctrl: game-state sequencer for the dino runner.
// Compares the cactus and dino bounding boxes once per video frame, counts
// cactus passes as a saturating 4-digit BCD score and runs the
// IDLE -> RUN -> HIT -> OVER flow with player restart.
//
// State table:
//   IDLE | waiting for the first restart; movers frozen
//   RUN  | game live; overlap and pass detection active
//   HIT  | collision seen; movers frozen while HIT_HOLD frames elapse
//   OVER | game over; score held until restart
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active-high
//   frame_tick in   one-cycle pulse per video frame
//   cactus_x/y in   cactus left/top edge (10 bits)
//   dino_x/y   in   dino left/top edge (10 bits)
//   restart    in   player restart request (level)
//   stop       out  freeze for obstacle/dino movers
//   wipe       out  one-cycle pulse returning the cactus to x=640
//   hit        out  high in HIT and OVER
//   score      out  four BCD digits, [15:12] most significant
//
// Build option: define COLLISION_GRACE_EN to require overlap on two
// consecutive frames before RUN -> HIT.
module collision_ctrl #(
  parameter int CACTUS_W = 15,
  parameter int CACTUS_H = 33,
  parameter int DINO_W   = 20,
  parameter int DINO_H   = 22,
  parameter int HIT_HOLD = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [9:0]  cactus_x,
  input  logic [9:0]  cactus_y,
  input  logic [9:0]  dino_x,
  input  logic [9:0]  dino_y,
  input  logic        restart,
  output logic        stop,
  output logic        wipe,
  output logic        hit,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [10:0] CW        = 11'(CACTUS_W);
  localparam logic [10:0] CH        = 11'(CACTUS_H);
  localparam logic [10:0] DW        = 11'(DINO_W);
  localparam logic [10:0] DH        = 11'(DINO_H);
  localparam logic [7:0]  HOLD_LOAD = 8'(HIT_HOLD - 1);

  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wipe_q, wipe_d;
`ifdef COLLISION_GRACE_EN
  logic        pending_q, pending_d;
`endif

  // Box edges widened to 11 bits so right/bottom edges never wrap.
  logic [10:0] cx, cy, dx, dy;
  logic [10:0] c_right, c_bottom, d_right, d_bottom;
  logic        overlap, arm_cond, pass_cond;

  assign cx       = {1'b0, cactus_x};
  assign cy       = {1'b0, cactus_y};
  assign dx       = {1'b0, dino_x};
  assign dy       = {1'b0, dino_y};
  assign c_right  = cx + CW;
  assign c_bottom = cy + CH;
  assign d_right  = dx + DW;
  assign d_bottom = dy + DH;

  assign overlap   = (cx < d_right) && (dx < c_right) &&
                     (cy < d_bottom) && (dy < c_bottom);
  // Cactus fully right of the dino arms a pass; fully left completes it.
  assign arm_cond  = (cx >= d_right);
  assign pass_cond = (c_right <= dx);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      score_q   <= 16'h0000;
      cnt_q     <= 8'd0;
      wipe_q    <= 1'b0;
`ifdef COLLISION_GRACE_EN
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      score_q   <= score_d;
      cnt_q     <= cnt_d;
      wipe_q    <= wipe_d;
`ifdef COLLISION_GRACE_EN
      pending_q <= pending_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    wipe_d    = 1'b0;
`ifdef COLLISION_GRACE_EN
    pending_d = pending_q;
`endif
    case (state_q)
      IDLE, OVER: begin
        if (frame_tick && restart) begin
          state_d   = RUN;
          wipe_d    = 1'b1;
          score_d   = 16'h0000;
          armed_d   = 1'b0;
`ifdef COLLISION_GRACE_EN
          pending_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (frame_tick) begin
          if (overlap) begin
`ifdef COLLISION_GRACE_EN
            if (pending_q) begin
              state_d   = HIT;
              cnt_d     = HOLD_LOAD;
              pending_d = 1'b0;
            end else begin
              pending_d = 1'b1;
            end
`else
            state_d = HIT;
            cnt_d   = HOLD_LOAD;
`endif
          end else begin
`ifdef COLLISION_GRACE_EN
            pending_d = 1'b0;
`endif
            if (armed_q && pass_cond) begin
              score_d = bcd_inc(score_q);
              armed_d = 1'b0;
            end else if (arm_cond) begin
              armed_d = 1'b1;
            end
          end
        end
      end
      HIT: begin
        // Down-counter loaded on entry; terminal count ends the hold.
        if (frame_tick) begin
          if (cnt_q == 8'd0) begin
            state_d = OVER;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stop  = (state_q != RUN);
  assign hit   = (state_q == HIT) || (state_q == OVER);
  assign wipe  = wipe_q;
  assign score = score_q;

endmodule

// File: tb/tb_collision_ctrl.sv
module tb_collision_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [9:0]  cactus_x, cactus_y, dino_x, dino_y;
  logic        restart;
  logic        stop, wipe, hit;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;
  int wipe_cycles = 0;
  int stop_seen_hi = 0;

  collision_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .cactus_x   (cactus_x),
    .cactus_y   (cactus_y),
    .dino_x     (dino_x),
    .dino_y     (dino_y),
    .restart    (restart),
    .stop       (stop),
    .wipe       (wipe),
    .hit        (hit),
    .score      (score)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wipe === 1'b1) wipe_cycles++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [9:0] cx, input logic [9:0] cy, input logic rs);
    cactus_x   = cx;
    cactus_y   = cy;
    restart    = rs;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    restart    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_pass();
    tick(10'd100, 10'd420, 1'b0);
    tick(10'd30, 10'd420, 1'b0);
  endtask

  // Drives RUN into HIT with the overlapping box (60,367).
  task automatic collide();
`ifdef COLLISION_GRACE_EN
    tick(10'd60, 10'd367, 1'b0);
    chk("grace_one_tick_stop", stop, 0);
    tick(10'd640, 10'd420, 1'b0);
    chk("grace_cleared_stop", stop, 0);
    tick(10'd60, 10'd367, 1'b0);
    chk("grace_first_again_stop", stop, 0);
    tick(10'd60, 10'd367, 1'b0);
`else
    tick(10'd60, 10'd367, 1'b0);
`endif
  endtask

  initial begin
    dino_x = 10'd50;
    dino_y = 10'd378;
    cactus_x = 10'd640;
    cactus_y = 10'd420;
    rst = 1'b1;
    frame_tick = 1'b1;
    restart = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stop", stop, 1);
    chk("rst_wipe", wipe, 0);
    chk("rst_hit", hit, 0);
    chk("rst_score", score, 16'h0000);
    rst = 1'b0;
    frame_tick = 1'b0;
    restart = 1'b0;

    tick(10'd640, 10'd420, 1'b0);
    chk("idle_no_restart_stop", stop, 1);
    restart = 1'b1;
    idle(3);
    chk("idle_restart_no_tick_stop", stop, 1);
    chk("idle_restart_no_tick_wipe", wipe, 0);

    tick(10'd640, 10'd420, 1'b1);
    chk("start_wipe", wipe, 1);
    chk("start_stop", stop, 0);
    chk("start_score", score, 16'h0000);
    idle(1);
    chk("start_wipe_drop", wipe, 0);

    // Full sweep with no vertical overlap: one pass only.
    for (int x = 640; x >= 0; x -= 2) begin
      tick(10'(x), 10'd420, 1'b0);
      if (stop !== 1'b0) stop_seen_hi++;
    end
    chk("sweep_stop_never_high", stop_seen_hi, 0);
    chk("sweep_score", score, 16'h0001);

    tick(10'd100, 10'd420, 1'b0);
    cactus_x = 10'd30;
    idle(3);
    chk("between_ticks_score", score, 16'h0001);
    tick(10'd30, 10'd420, 1'b0);
    chk("pass2_score", score, 16'h0002);
    tick(10'd30, 10'd420, 1'b0);
    chk("no_double_count", score, 16'h0002);

    for (int i = 0; i < 8; i++) do_pass();
    chk("bcd_carry_10", score, 16'h0010);
    for (int i = 0; i < 89; i++) do_pass();
    chk("score_99", score, 16'h0099);
    do_pass();
    chk("bcd_carry_100", score, 16'h0100);
    for (int i = 0; i < 9899; i++) do_pass();
    chk("score_9999", score, 16'h9999);
    do_pass();
    chk("score_saturate", score, 16'h9999);

    // Arm, then collide: restart from OVER must drop the armed flag.
    tick(10'd100, 10'd420, 1'b0);
    collide();
    chk("hit_stop", stop, 1);
    chk("hit_hit", hit, 1);
    chk("hit_score_held", score, 16'h9999);

    // 60 ticks with restart held: 59 ignored in HIT, 60th reaches OVER.
    stop_seen_hi = 0;
    for (int i = 0; i < 60; i++) begin
      tick(10'd60, 10'd367, 1'b1);
      if (stop !== 1'b1) stop_seen_hi++;
    end
    chk("hit_hold_stop_stays", stop_seen_hi, 0);
    chk("over_hit", hit, 1);
    chk("over_score", score, 16'h9999);
    chk("over_wipe", wipe, 0);

    tick(10'd640, 10'd420, 1'b1);
    chk("over_restart_wipe", wipe, 1);
    chk("over_restart_stop", stop, 0);
    chk("over_restart_hit", hit, 0);
    chk("over_restart_score", score, 16'h0000);
    tick(10'd30, 10'd420, 1'b0);
    chk("armed_cleared", score, 16'h0000);
    do_pass();
    chk("post_restart_pass", score, 16'h0001);

    collide();
    chk("hit2_hit", hit, 1);
    rst = 1'b1;
    restart = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart = 1'b0;
    frame_tick = 1'b0;
    chk("rst_in_hit_stop", stop, 1);
    chk("rst_in_hit_wipe", wipe, 0);
    chk("rst_in_hit_hit", hit, 0);
    chk("rst_in_hit_score", score, 16'h0000);
    tick(10'd640, 10'd420, 1'b0);
    chk("after_rst_idle_stop", stop, 1);

    idle(2);
    chk("wipe_total_cycles", wipe_cycles, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_ctrl.md
COLLISION_CTRL -- requirements
Module: collision_ctrl

Interface
REQ-001 SHALL have parameter CACTUS_W, default 15, meaning cactus box width in pixels.
REQ-002 SHALL have parameter CACTUS_H, default 33, meaning cactus box height in pixels.
REQ-003 SHALL have parameter DINO_W, default 20, meaning dino box width in pixels.
REQ-004 SHALL have parameter DINO_H, default 22, meaning dino box height in pixels.
REQ-005 SHALL have parameter HIT_HOLD, default 60, meaning frames spent in HIT before OVER (range 1..255).
REQ-006 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- cactus_x  in  10  cactus left edge.
- cactus_y  in  10  cactus top edge.
- dino_x  in  10  dino left edge.
- dino_y  in  10  dino top edge.
- restart  in  1  player restart request, level.
- stop  out  1  freeze for obstacle/dino movers.
- wipe  out  1  one-cycle pulse forcing cactus back to x=640.
- hit  out  1  high in HIT and OVER.
- score  out  16  four BCD digits, [15:12] most significant.

Function
REQ-007 SHALL implement states IDLE, RUN, HIT, OVER; all state changes except reset occur only on cycles with frame_tick=1.
REQ-008 Overlap SHALL be true iff cactus_x < dino_x+DINO_W and dino_x < cactus_x+CACTUS_W and cactus_y < dino_y+DINO_H and dino_y < cactus_y+CACTUS_H; sums computed at 11 bits, no wrap.
REQ-009 IDLE: stop=1; on frame_tick with restart=1 -> RUN, wipe=1 for that one cycle, score cleared to 0000.
REQ-010 RUN: stop=0; on frame_tick with overlap -> HIT, stop=1 from the next cycle.
REQ-011 RUN pass detection: armed flag set when cactus_x >= dino_x+DINO_W; on frame_tick with flag set and cactus_x+CACTUS_W <= dino_x, score increments by 1 (BCD carry) and flag clears; exactly one increment per cactus pass.
REQ-012 Score SHALL saturate at 9999; no wrap to 0000.
REQ-013 Overlap and pass condition on the same frame_tick: HIT taken, score unchanged.
REQ-014 HIT: stop=1, hit=1; frame counter counts frame_ticks; after HIT_HOLD ticks -> OVER; restart ignored in HIT.
REQ-015 OVER: stop=1, hit=1, score held; on frame_tick with restart=1 -> RUN, wipe pulse, score cleared, armed flag cleared.
REQ-016 wipe SHALL be high for exactly one clk cycle per restart and never otherwise.
REQ-017 Inputs sampled only on frame_tick; changes between ticks have no effect.

Reset
REQ-018 On rst=1 at a clk edge: state IDLE, stop=1, wipe=0, hit=0, score=0000, armed flag=0, frame counter=0.
REQ-019 rst SHALL override frame_tick and restart in the same cycle, including mid-HIT.

Configuration
REQ-020 Macro COLLISION_GRACE_EN: when defined, RUN->HIT requires overlap on two consecutive frame_ticks (a non-overlap tick clears the pending count); when undefined, a single overlapping tick suffices.

Verification
REQ-021 rst, then restart=1 on a frame_tick -> wipe one cycle, state RUN, stop=0, score=0000.
REQ-022 RUN, dino (50,378), cactus_x swept 640->0 by 2 per tick, cactus_y=420 (no vertical overlap) -> score=0001, stop stays 0.
REQ-023 RUN, dino (50,378), cactus (60,367) on a tick -> stop=1 next cycle, hit=1; after 60 ticks state OVER; restart during HIT ignored.
REQ-024 Score preloaded to 9999 via 9999 passes (or forced) then another pass -> score stays 9999.
REQ-025 With COLLISION_GRACE_EN: overlap on one tick then none -> stays RUN; overlap on two consecutive ticks -> HIT.
REQ-026 rst asserted in HIT with restart=1 -> IDLE, stop=1, wipe=0, score=0000.
